vec_mul_seq: RTL and testbench
==============================

// Module: vec_mul_seq
// PURPOSE
//  Command-driven sequencer for one vec_mul dot-product engine in the Processing Element.
//  Accepts a job: N dot products, plus K/X base addresses. Streams K and X vectors from
//  two sync-read vector memories into the internal vec_mul and tracks validity through
//  the pipeline. Emits the N results on a valid/ready stream and stalls the whole
//  pipeline on backpressure.
// PARAMETERS
//  C     8   lanes per vector (vec_mul C)
//  W_X   8   signed X element width
//  W_K   8   signed K element width
//  AW    10  vector-memory address width (one address = one full C-lane vector)
//  LW    16  job length width
//  derived: DEPTH=$clog2(C), W_Y=W_X+W_K+DEPTH, LAT=DEPTH+2
// PORTS
//  clk          in   1        clock
//  rst          in   1        synchronous active-high reset
//  cmd_valid    in   1        job request
//  cmd_ready    out  1        high only in IDLE
//  cmd_len      in   LW       number of dot products N (0 allowed)
//  cmd_k_base   in   AW       first K vector address
//  cmd_x_base   in   AW       first X vector address
//  cmd_k_fixed  in   1        1: K address constant (weight reuse); 0: K increments
//  k_rd_en      out  1        K memory read enable; data holds when low
//  k_rd_addr    out  AW       K read address
//  k_rd_data    in   C*W_K    K vector, 1-cycle read latency
//  x_rd_en      out  1        X memory read enable; data holds when low
//  x_rd_addr    out  AW       X read address
//  x_rd_data    in   C*W_X    X vector, 1-cycle read latency
//  res_valid    out  1        result available
//  res_ready    in   1        consumer accepts
//  res_data     out  W_Y      signed dot product
//  res_last     out  1        with res_valid: result N of the job
//  busy         out  1        state != IDLE
//  done         out  1        1-cycle pulse when the job completes
// BEHAVIOUR
//  Reset: state=IDLE, tag pipe cleared, all counters 0. res_valid/res_last/done/busy/
//   k_rd_en/x_rd_en=0, vec_mul enable=0. cmd_ready=1 from the first cycle after reset.
//  adv = !(res_valid && !res_ready). This is the single global advance.
//   vec_mul enable = adv && state!=IDLE.
//   Read enables and the tag shift move only when adv=1.
//  FSM:
//   IDLE -> RUN on cmd_valid, if cmd_len!=0. Latch bases, len, k_fixed; zero counters.
//   IDLE -> DONE on cmd_valid, if cmd_len==0.
//   RUN: each adv cycle issues read i (k_rd_en=x_rd_en=1).
//    x_addr = x_base+i.
//    k_addr = k_base+i, or k_base if k_fixed.
//    Addresses wrap mod 2^AW.
//    After issue N-1 -> DRAIN.
//   DRAIN: no issue. When the tag pipe is empty and the last result is accepted -> DONE.
//   DONE: done=1 for one cycle -> IDLE. cmd is not accepted in DONE.
//  Tag pipe: LAT bits. tag[0] <= issue; tag[j] <= tag[j-1]. res_valid = tag[LAT-1].
//   Path: memory (1) + mul reg (1) + DEPTH adder regs. The first result appears LAT
//   cycles after the first issue with no stalls (C=8: 5 cycles).
//   Throughput is 1 result/cycle.
//  res_data/res_valid/res_last hold stable while res_ready=0.
//   Memories and vec_mul freeze, and no lane data is lost.
//  res_last is driven from an output counter: accepted results, compared against N-1.
//  Arithmetic: signed products; W_Y never overflows (C*2^(W_X+W_K-2) fits).
//  Reset mid-job: abort immediately. Everything returns to reset values next cycle;
//   in-flight results are dropped and no done is produced.
// STRUCTURE
//  pe_pkg: state enum {IDLE,RUN,DRAIN,DONE}; function lat(C)=$clog2(C)+2; W_Y helper.
//  Sub-module: vec_mul instance.
//   k/x come from rd_data; enable = adv && busy; v_valid is left unused.
//   Validity comes from the local tag pipe only.
//  Local logic: FSM, issue counter, output counter, LAT-bit tag shift register.
// TESTING (C=8, W_X=W_K=8)
//  1. Single product: N=1, K lanes all 1, X=1..8, res_ready=1.
//     -> res_valid 5 cycles after issue; res_data=36, res_last=1; done next cycle.
//  2. Stream: N=4, res_ready=1.
//     -> 4 results on consecutive cycles, in address order; res_last only on the 4th.
//  3. Backpressure: N=6, drop res_ready 3 cycles at result 2.
//     -> res_data held stable, rd_en=0 during the stall; all 6 results correct and in order.
//  4. Signed extreme: all K=-128, X=-128.
//     -> res_data=131072. With K=-128, X=127 -> -130048.
//  5. Corner commands:
//     - N=0 -> done 1 cycle after accept, no res_valid.
//     - k_fixed=1, k_base=5, x_base=1022, N=4 -> k_rd_addr stays 5; x_rd_addr 1022,1023,0,1.
//  6. rst asserted during DRAIN with res_ready=0.
//     -> next cycle res_valid=0, busy=0, cmd_ready=1; a new N=1 job completes correctly.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and sizing helpers for the processing-element datapath.
package pe_pkg;

  // Sequencer states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Issue-to-result latency: one memory read cycle, one multiplier register,
  // and one register per adder-tree level.
  function automatic int lat(input int c);
    return $clog2(c) + 2;
  endfunction

  // Dot-product width. The sum of C full-scale signed products cannot overflow it.
  function automatic int w_y(input int c, input int w_x, input int w_k);
    return w_x + w_k + $clog2(c);
  endfunction

endpackage

// File: rtl/vec_mul.sv
// C-lane signed dot-product engine: one product register stage followed by a
// registered binary adder tree. The whole pipeline advances only when en=1.
// C must be a power of two.
module vec_mul
  import pe_pkg::*;
#(
  parameter int C   = 8,
  parameter int W_X = 8,
  parameter int W_K = 8,
  parameter int W_Y = w_y(C, W_X, W_K)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [C*W_K-1:0]     k,
  input  logic [C*W_X-1:0]     x,
  output logic [W_Y-1:0]       y
);

  localparam int DEPTH = $clog2(C);
  localparam int W_P   = W_X + W_K;

  logic signed [W_P-1:0] prod_d [C];
  logic signed [W_P-1:0] prod_q [C];

  // Per-lane signed products of the current K/X vectors.
  always_comb begin
    for (int i = 0; i < C; i++) begin
      prod_d[i] = W_P'($signed(k[i*W_K +: W_K])) * W_P'($signed(x[i*W_X +: W_X]));
    end
  end

  // Product register stage, frozen while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < C; i++) prod_q[i] <= '0;
    end else if (en) begin
      prod_q <= prod_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_lvl
      localparam int N = C >> (gi + 1);
      logic signed [W_Y-1:0] sum_d [N];
      logic signed [W_Y-1:0] sum_q [N];

      if (gi == 0) begin : g_src
        // First tree level: pairwise sums of sign-extended products.
        always_comb begin
          for (int j = 0; j < N; j++) begin
            sum_d[j] = W_Y'(prod_q[2*j]) + W_Y'(prod_q[2*j+1]);
          end
        end
      end else begin : g_src
        // Deeper levels: pairwise sums of the previous level's registers.
        always_comb begin
          for (int j = 0; j < N; j++) begin
            sum_d[j] = g_lvl[gi-1].sum_q[2*j] + g_lvl[gi-1].sum_q[2*j+1];
          end
        end
      end

      // One register per tree level, advancing with the rest of the pipe.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int j = 0; j < N; j++) sum_q[j] <= '0;
        end else if (en) begin
          sum_q <= sum_d;
        end
      end
    end

    if (DEPTH == 0) begin : g_out
      assign y = W_Y'(prod_q[0]);
    end else begin : g_out
      assign y = g_lvl[DEPTH-1].sum_q[0];
    end
  endgenerate

endmodule

// File: rtl/vec_mul_seq.sv
// Job sequencer for one vec_mul engine: issues N K/X vector reads, tracks
// validity with a tag shift register aligned to the datapath, and streams
// results out on valid/ready. One global advance signal freezes memories,
// datapath and tags together on backpressure, so no lane data is lost.
module vec_mul_seq
  import pe_pkg::*;
#(
  parameter int C   = 8,
  parameter int W_X = 8,
  parameter int W_K = 8,
  parameter int AW  = 10,
  parameter int LW  = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [LW-1:0]                     cmd_len,
  input  logic [AW-1:0]                     cmd_k_base,
  input  logic [AW-1:0]                     cmd_x_base,
  input  logic                              cmd_k_fixed,
  output logic                              k_rd_en,
  output logic [AW-1:0]                     k_rd_addr,
  input  logic [C*W_K-1:0]                  k_rd_data,
  output logic                              x_rd_en,
  output logic [AW-1:0]                     x_rd_addr,
  input  logic [C*W_X-1:0]                  x_rd_data,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [w_y(C, W_X, W_K)-1:0]       res_data,
  output logic                              res_last,
  output logic                              busy,
  output logic                              done
);

  localparam int W_Y = w_y(C, W_X, W_K);
  localparam int LAT = lat(C);

  state_e         state_q, state_d;
  logic [LW-1:0]  len_q, len_d;
  logic [LW-1:0]  issue_cnt_q, issue_cnt_d;
  logic [LW-1:0]  out_cnt_q, out_cnt_d;
  logic [AW-1:0]  k_base_q, k_base_d;
  logic [AW-1:0]  x_base_q, x_base_d;
  logic           k_fixed_q, k_fixed_d;
  logic [LAT-1:0] tag_q, tag_d;

  logic adv;
  logic issue;
  logic accept;
  logic last_out;
  logic mul_en;

  // Global advance: everything holds while a presented result is refused.
  assign res_valid = tag_q[LAT-1];
  assign adv       = !(res_valid && !res_ready);
  assign issue     = (state_q == S_RUN) && adv;
  assign accept    = res_valid && res_ready;
  assign last_out  = (out_cnt_q == len_q - LW'(1));
  assign res_last  = res_valid && last_out;
  assign mul_en    = adv && (state_q != S_IDLE);

  // Read requests; addresses wrap naturally at AW bits.
  assign k_rd_en   = issue;
  assign x_rd_en   = issue;
  assign x_rd_addr = x_base_q + AW'(issue_cnt_q);
  assign k_rd_addr = k_fixed_q ? k_base_q : (k_base_q + AW'(issue_cnt_q));

  // FSM next state, command latching, counters and status outputs.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    k_base_d    = k_base_q;
    x_base_d    = x_base_q;
    k_fixed_d   = k_fixed_q;
    issue_cnt_d = issue_cnt_q;
    out_cnt_d   = out_cnt_q;
    cmd_ready   = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;

    if (accept) out_cnt_d = out_cnt_q + LW'(1);

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          len_d       = cmd_len;
          k_base_d    = cmd_k_base;
          x_base_d    = cmd_x_base;
          k_fixed_d   = cmd_k_fixed;
          issue_cnt_d = '0;
          out_cnt_d   = '0;
          state_d     = (cmd_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (adv) begin
          issue_cnt_d = issue_cnt_q + LW'(1);
          if (issue_cnt_q == len_q - LW'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Finish once the final result leaves with nothing else in flight.
        if (accept && last_out && (tag_q[LAT-2:0] == '0)) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Validity tags shift in step with the memory + datapath stages.
  always_comb begin
    tag_d = tag_q;
    if (adv) tag_d = {tag_q[LAT-2:0], issue};
  end

  // State, job context, counters and tag pipe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      k_base_q    <= '0;
      x_base_q    <= '0;
      k_fixed_q   <= 1'b0;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      k_base_q    <= k_base_d;
      x_base_q    <= x_base_d;
      k_fixed_q   <= k_fixed_d;
      issue_cnt_q <= issue_cnt_d;
      out_cnt_q   <= out_cnt_d;
      tag_q       <= tag_d;
    end
  end

  vec_mul #(
    .C   (C),
    .W_X (W_X),
    .W_K (W_K),
    .W_Y (W_Y)
  ) u_vec_mul (
    .clk (clk),
    .rst (rst),
    .en  (mul_en),
    .k   (k_rd_data),
    .x   (x_rd_data),
    .y   (res_data)
  );

endmodule

// File: tb/tb_vec_mul_seq.sv
// Randomized and directed bench for vec_mul_seq with a queue-based dot-product model.
module tb_vec_mul_seq;

  localparam int C   = 8;
  localparam int W_X = 8;
  localparam int W_K = 8;
  localparam int AW  = 10;
  localparam int LW  = 16;
  localparam int W_Y = W_X + W_K + $clog2(C);
  localparam int MEMSZ = 1 << AW;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [LW-1:0]    cmd_len = '0;
  logic [AW-1:0]    cmd_k_base = '0;
  logic [AW-1:0]    cmd_x_base = '0;
  logic             cmd_k_fixed = 1'b0;
  logic             k_rd_en;
  logic [AW-1:0]    k_rd_addr;
  logic [C*W_K-1:0] k_rd_data = '0;
  logic             x_rd_en;
  logic [AW-1:0]    x_rd_addr;
  logic [C*W_X-1:0] x_rd_data = '0;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic [W_Y-1:0]   res_data;
  logic             res_last;
  logic             busy;
  logic             done;

  vec_mul_seq #(.C(C), .W_X(W_X), .W_K(W_K), .AW(AW), .LW(LW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_k_base(cmd_k_base), .cmd_x_base(cmd_x_base), .cmd_k_fixed(cmd_k_fixed),
    .k_rd_en(k_rd_en), .k_rd_addr(k_rd_addr), .k_rd_data(k_rd_data),
    .x_rd_en(x_rd_en), .x_rd_addr(x_rd_addr), .x_rd_data(x_rd_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_last(res_last), .busy(busy), .done(done)
  );

  initial forever #5 clk = ~clk;

  // Vector memories with one-cycle registered read that hold when not enabled.
  logic [C*W_K-1:0] k_mem [MEMSZ];
  logic [C*W_X-1:0] x_mem [MEMSZ];
  always @(posedge clk) begin
    if (k_rd_en) k_rd_data <= k_mem[k_rd_addr];
    if (x_rd_en) x_rd_data <= x_mem[x_rd_addr];
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain signed dot product of two stored vectors.
  function automatic longint dot(input int ka, input int xa);
    longint s;
    byte kb;
    byte xb;
    s = 0;
    for (int l = 0; l < C; l++) begin
      kb = k_mem[ka][8*l +: 8];
      xb = x_mem[xa][8*l +: 8];
      s += longint'(kb) * longint'(xb);
    end
    return s;
  endfunction

  longint exp_res[$];
  int     exp_kaddr[$];
  int     exp_xaddr[$];
  int     job_n, n_acc, stall_cyc, done_cnt;
  int     issue_first, valid_first, acc_first, acc_last, done_cyc, cmd_cyc;
  bit     saw_valid;
  longint last_data;
  int     cyc = 0;
  int     ready_mode = 0;
  int     stall_left = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Consumer ready pattern: 0 always, 1 random, 2 three-cycle stall at result 2, 3 never.
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0: res_ready = 1'b1;
      1: res_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (n_acc == 2 && stall_left > 0) begin
          res_ready = 1'b0;
          stall_left--;
        end else begin
          res_ready = 1'b1;
        end
      end
      default: res_ready = 1'b0;
    endcase
  end

  // Output/issue monitor, sampling on the falling edge.
  bit             prev_stall = 0;
  logic [W_Y-1:0] prev_data;
  logic           prev_last;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (k_rd_en) begin
        if (issue_first < 0) issue_first = cyc;
        check("x_rd_en_with_k", x_rd_en, 1);
        if (exp_kaddr.size() == 0) begin
          check("extra_issue", 1, 0);
        end else begin
          check("k_rd_addr", k_rd_addr, exp_kaddr.pop_front());
          check("x_rd_addr", x_rd_addr, exp_xaddr.pop_front());
        end
      end
      if (res_valid) begin
        saw_valid = 1;
        if (valid_first < 0) valid_first = cyc;
      end
      if (prev_stall) begin
        check("hold_valid", res_valid, 1);
        check("hold_data", res_data, prev_data);
        check("hold_last", res_last, prev_last);
      end
      if (res_valid && !res_ready) begin
        stall_cyc++;
        check("stall_rd_en", k_rd_en, 0);
      end
      if (res_valid && res_ready) begin
        if (exp_res.size() == 0) begin
          check("extra_result", 1, 0);
        end else begin
          check("res_data", longint'($signed(res_data)), exp_res.pop_front());
          check("res_last", res_last, (n_acc == job_n - 1));
        end
        $display("txn %0d: cyc=%0d res_data=%0d res_last=%0b",
                 n_acc, cyc, $signed(res_data), res_last);
        if (acc_first < 0) acc_first = cyc;
        acc_last  = cyc;
        last_data = longint'($signed(res_data));
        n_acc++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = res_valid && !res_ready;
      prev_data  = res_data;
      prev_last  = res_last;
    end
  end

  task automatic prepare(input int n, input int kb, input int xb, input bit kf, input int mode);
    int ka;
    int xa;
    exp_res.delete();
    exp_kaddr.delete();
    exp_xaddr.delete();
    for (int i = 0; i < n; i++) begin
      ka = kf ? kb : (kb + i) % MEMSZ;
      xa = (xb + i) % MEMSZ;
      exp_kaddr.push_back(ka);
      exp_xaddr.push_back(xa);
      exp_res.push_back(dot(ka, xa));
    end
    job_n = n; n_acc = 0; stall_cyc = 0; done_cnt = 0; saw_valid = 0;
    issue_first = -1; valid_first = -1; acc_first = -1; acc_last = -1; done_cyc = -1;
    ready_mode = mode; stall_left = 3;
  endtask

  task automatic send_cmd(input int n, input int kb, input int xb, input bit kf);
    int w;
    @(posedge clk);
    #1;
    w = 0;
    while (!cmd_ready && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (!cmd_ready) check("cmd_ready_wait", 0, 1);
    cmd_valid = 1; cmd_len = LW'(n); cmd_k_base = AW'(kb); cmd_x_base = AW'(xb);
    cmd_k_fixed = kf;
    cmd_cyc = cyc;
    @(posedge clk);
    #1;
    cmd_valid = 0;
  endtask

  task automatic run_job(input int n, input int kb, input int xb, input bit kf, input int mode);
    prepare(n, kb, xb, kf, mode);
    send_cmd(n, kb, xb, kf);
    for (int t = 0; t < 3000 && done_cnt == 0; t++) @(negedge clk);
    if (done_cnt == 0) check("done_timeout", 0, 1);
    @(negedge clk);
    check("done_pulses", done_cnt, 1);
    check("n_results", n_acc, n);
    check("results_left", exp_res.size(), 0);
    check("issues_left", exp_kaddr.size(), 0);
    check("idle_after_done", cmd_ready, 1);
    ready_mode = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < MEMSZ; i++) begin
      k_mem[i] = {$urandom, $urandom};
      x_mem[i] = {$urandom, $urandom};
    end
    k_mem[0] = {8{8'h01}};
    for (int l = 0; l < C; l++) x_mem[0][8*l +: 8] = 8'(l + 1);
    k_mem[300] = {8{8'h80}};
    x_mem[300] = {8{8'h80}};
    x_mem[301] = {8{8'h7f}};

    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_done", done, 0);
    check("rst_k_rd_en", k_rd_en, 0);

    // Single product with known data.
    run_job(1, 0, 0, 0, 0);
    check("t1_latency", valid_first - issue_first, 5);
    check("t1_data", last_data, 36);
    check("t1_done_after_last", done_cyc - acc_last, 1);

    // Back-to-back stream.
    run_job(4, 16, 40, 0, 0);
    check("t2_consecutive", acc_last - acc_first, 3);

    // Three-cycle backpressure at result 2.
    run_job(6, 100, 200, 0, 2);
    check("t3_stall_cycles", stall_cyc, 3);

    // Signed extremes.
    run_job(1, 300, 300, 0, 0);
    check("t4_neg_neg", last_data, 131072);
    run_job(1, 300, 301, 0, 0);
    check("t4_neg_pos", last_data, -130048);

    // Zero-length job and fixed-K wrapping job.
    run_job(0, 0, 0, 0, 0);
    check("t5_len0_done_delay", done_cyc - cmd_cyc, 1);
    check("t5_len0_no_valid", saw_valid, 0);
    run_job(4, 5, 1022, 1, 0);

    // Reset while draining with the consumer stalled.
    prepare(3, 50, 60, 0, 3);
    send_cmd(3, 50, 60, 0);
    for (int t = 0; t < 50 && !res_valid; t++) @(negedge clk);
    check("t6_valid_before_rst", res_valid, 1);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    @(negedge clk);
    check("t6_res_valid", res_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_cmd_ready", cmd_ready, 1);
    #1 rst = 0;
    ready_mode = 0;
    exp_res.delete();
    exp_kaddr.delete();
    exp_xaddr.delete();
    repeat (3) @(negedge clk);
    check("t6_no_done", done_cnt, 0);
    check("t6_no_valid_after", res_valid, 0);
    run_job(1, 7, 9, 0, 0);

    // Randomized jobs with random backpressure.
    for (int r = 0; r < 10; r++) begin
      run_job($urandom_range(1, 24), $urandom_range(0, MEMSZ - 1),
              $urandom_range(0, MEMSZ - 1), 1'($urandom_range(0, 1)), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
